fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS datapath, directly upstream of the decode unit. It owns the PC, issues instruction reads to the instruction cache through the datapath–cache interface, and latches each fetched word with its PC and PC+4 into the IF/ID register. It honours stall, flush and control-flow redirects from downstream stages, and stops fetching after it captures a HALT opcode.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its neighbours: instruction cache,
// hazard unit, redirect source and the decode stage fed by the IF/ID register.
interface fetch_unit_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_ins;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    logic        fetch_halted;

    modport master (
        output imemREN, imemaddr, ifid_valid, ifid_ins, ifid_pc, ifid_npc, fetch_halted,
        input  ihit, imemload, stall, flush, redirect, redirect_pc
    );

    modport slave (
        input  imemREN, imemaddr, ifid_valid, ifid_ins, ifid_pc, ifid_npc, fetch_halted,
        output ihit, imemload, stall, flush, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, reads the instruction cache and
// fills the IF/ID register, honouring stall, flush, redirects and HALT.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic CLK,
    input  logic RST,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {StFetch, StDrain, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        valid_q, valid_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] npc_q, npc_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        ins_d   = ins_q;
        ifpc_d  = ifpc_q;
        npc_d   = npc_q;
        case (state_q)
            StFetch: begin
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    if (bus.ihit) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = StDrain;
                    end
                end else if (bus.flush) begin
                    valid_d = 1'b0;
                    if (bus.ihit && !bus.stall) pc_d = pc_plus4;
                end else if (!bus.stall) begin
                    if (bus.ihit) begin
                        valid_d = 1'b1;
                        ins_d   = bus.imemload;
                        ifpc_d  = pc_q;
                        npc_d   = pc_plus4;
                        pc_d    = pc_plus4;
                        if (bus.imemload[31:26] == HALT_OP) state_d = StHalted;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                // The outstanding word belongs to the wrong path and is never captured.
                valid_d = 1'b0;
                if (bus.redirect) pend_d = target;
                if (bus.ihit) begin
                    pc_d    = bus.redirect ? target : pend_q;
                    state_d = StFetch;
                end
            end
            StHalted: begin
                if (bus.redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end else if (bus.flush || !bus.stall) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = StFetch;
        endcase
        halted_d = (state_d == StHalted);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StFetch;
            pc_q     <= {PC_INIT[31:2], 2'b00};
            pend_q   <= 32'd0;
            valid_q  <= 1'b0;
            ins_q    <= 32'd0;
            ifpc_q   <= 32'd0;
            npc_q    <= 32'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            ins_q    <= ins_d;
            ifpc_q   <= ifpc_d;
            npc_q    <= npc_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imemREN      = (state_q != StHalted);
    assign bus.imemaddr     = pc_q;
    assign bus.ifid_valid   = valid_q;
    assign bus.ifid_ins     = ins_q;
    assign bus.ifid_pc      = ifpc_q;
    assign bus.ifid_npc     = npc_q;
    assign bus.fetch_halted = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, miss, stall, redirect
// during miss, flush, HALT, PC wrap and reset from DRAIN/HALTED.
module tb_fetch_unit;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.ihit        = 1'b0;
        bus.imemload    = 32'd0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        step();
        step();
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.ifid_valid); end
        checks++; if (bus.ifid_ins !== 32'd0) begin errors++; $display("FAIL rst_ins: got %h want 0", bus.ifid_ins); end
        checks++; if (bus.ifid_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h want 0", bus.ifid_pc); end
        checks++; if (bus.ifid_npc !== 32'd0) begin errors++; $display("FAIL rst_npc: got %h want 0", bus.ifid_npc); end
        checks++; if (bus.fetch_halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", bus.fetch_halted); end
        RST = 1'b0;
        checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL rst_ren: got %b want 1", bus.imemREN); end
        checks++; if (bus.imemaddr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.imemaddr); end
    endtask

    task automatic test_straight();
        bus.ihit = 1'b1;
        bus.imemload = 32'h2001_0001;
        step();
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL sl_valid0: got %b want 1", bus.ifid_valid); end
        checks++; if (bus.ifid_ins !== 32'h2001_0001) begin errors++; $display("FAIL sl_ins0: got %h want 20010001", bus.ifid_ins); end
        checks++; if (bus.ifid_pc !== 32'h0) begin errors++; $display("FAIL sl_pc0: got %h want 0", bus.ifid_pc); end
        checks++; if (bus.ifid_npc !== 32'h4) begin errors++; $display("FAIL sl_npc0: got %h want 4", bus.ifid_npc); end
        bus.imemload = 32'h2002_0002;
        step();
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL sl_valid1: got %b want 1", bus.ifid_valid); end
        checks++; if (bus.ifid_ins !== 32'h2002_0002) begin errors++; $display("FAIL sl_ins1: got %h want 20020002", bus.ifid_ins); end
        checks++; if (bus.ifid_pc !== 32'h4) begin errors++; $display("FAIL sl_pc1: got %h want 4", bus.ifid_pc); end
        checks++; if (bus.ifid_npc !== 32'h8) begin errors++; $display("FAIL sl_npc1: got %h want 8", bus.ifid_npc); end
    endtask

    task automatic test_miss();
        bus.ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.imemaddr !== 32'h8) begin errors++; $display("FAIL miss_addr%0d: got %h want 8", i, bus.imemaddr); end
            checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL miss_valid%0d: got %b want 0", i, bus.ifid_valid); end
        end
        bus.ihit = 1'b1;
        bus.imemload = 32'h2003_0003;
        step();
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL miss_cap_valid: got %b want 1", bus.ifid_valid); end
        checks++; if (bus.ifid_pc !== 32'h8) begin errors++; $display("FAIL miss_cap_pc: got %h want 8", bus.ifid_pc); end
        checks++; if (bus.ifid_ins !== 32'h2003_0003) begin errors++; $display("FAIL miss_cap_ins: got %h want 20030003", bus.ifid_ins); end
    endtask

    task automatic test_stall();
        bus.imemload = 32'h2004_0004;
        step();
        bus.stall = 1'b1;
        bus.imemload = 32'hDEAD_BEEC;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.ifid_pc !== 32'hC) begin errors++; $display("FAIL stall_pc%0d: got %h want c", i, bus.ifid_pc); end
            checks++; if (bus.ifid_ins !== 32'h2004_0004) begin errors++; $display("FAIL stall_ins%0d: got %h want 20040004", i, bus.ifid_ins); end
            checks++; if (bus.imemaddr !== 32'h10) begin errors++; $display("FAIL stall_addr%0d: got %h want 10", i, bus.imemaddr); end
            checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL stall_ren%0d: got %b want 1", i, bus.imemREN); end
        end
        bus.stall = 1'b0;
        bus.imemload = 32'h2005_0005;
        step();
        checks++; if (bus.ifid_pc !== 32'h10) begin errors++; $display("FAIL stall_resume_pc: got %h want 10", bus.ifid_pc); end
        checks++; if (bus.ifid_ins !== 32'h2005_0005) begin errors++; $display("FAIL stall_resume_ins: got %h want 20050005", bus.ifid_ins); end
    endtask

    task automatic test_redirect();
        // Redirect coincident with a hit; misaligned target is forced aligned.
        bus.ihit = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h12;
        step();
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL rdh_valid: got %b want 0", bus.ifid_valid); end
        checks++; if (bus.imemaddr !== 32'h10) begin errors++; $display("FAIL rdh_addr: got %h want 10", bus.imemaddr); end
        bus.ihit = 1'b0;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.imemaddr !== 32'h10) begin errors++; $display("FAIL drain_addr0: got %h want 10", bus.imemaddr); end
        step();
        checks++; if (bus.imemaddr !== 32'h10) begin errors++; $display("FAIL drain_addr1: got %h want 10", bus.imemaddr); end
        checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL drain_ren: got %b want 1", bus.imemREN); end
        bus.ihit = 1'b1;
        bus.imemload = 32'hBAD0_0000;
        step();
        checks++; if (bus.imemaddr !== 32'h40) begin errors++; $display("FAIL drain_target: got %h want 40", bus.imemaddr); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL drain_drop: got %b want 0", bus.ifid_valid); end
        bus.imemload = 32'h2006_0006;
        step();
        checks++; if (bus.ifid_pc !== 32'h40) begin errors++; $display("FAIL rd_cap_pc: got %h want 40", bus.ifid_pc); end
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL rd_cap_valid: got %b want 1", bus.ifid_valid); end
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.ifid_valid); end
        checks++; if (bus.imemaddr !== 32'h48) begin errors++; $display("FAIL flush_addr: got %h want 48", bus.imemaddr); end
    endtask

    task automatic test_halt();
        bus.ihit = 1'b1;
        bus.imemload = 32'hFFFF_FFFF;
        step();
        checks++; if (bus.fetch_halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", bus.fetch_halted); end
        checks++; if (bus.imemREN !== 1'b0) begin errors++; $display("FAIL halt_ren: got %b want 0", bus.imemREN); end
        checks++; if (bus.ifid_pc !== 32'h48) begin errors++; $display("FAIL halt_pc: got %h want 48", bus.ifid_pc); end
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_valid: got %b want 1", bus.ifid_valid); end
        bus.ihit = 1'b0;
        step();
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble: got %b want 0", bus.ifid_valid); end
        checks++; if (bus.fetch_halted !== 1'b1) begin errors++; $display("FAIL halt_stay: got %b want 1", bus.fetch_halted); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.fetch_halted !== 1'b0) begin errors++; $display("FAIL unhalt_flag: got %b want 0", bus.fetch_halted); end
        checks++; if (bus.imemaddr !== 32'h100) begin errors++; $display("FAIL unhalt_addr: got %h want 100", bus.imemaddr); end
        checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL unhalt_ren: got %b want 1", bus.imemREN); end
    endtask

    task automatic test_wrap();
        bus.ihit = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        bus.imemload = 32'h2007_0007;
        step();
        checks++; if (bus.ifid_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", bus.ifid_pc); end
        checks++; if (bus.ifid_npc !== 32'h0) begin errors++; $display("FAIL wrap_npc: got %h want 0", bus.ifid_npc); end
        checks++; if (bus.imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", bus.imemaddr); end
    endtask

    task automatic test_reset_halted();
        bus.ihit = 1'b1;
        bus.imemload = 32'hFFFF_FFFF;
        step();
        checks++; if (bus.fetch_halted !== 1'b1) begin errors++; $display("FAIL rh_pre: got %b want 1", bus.fetch_halted); end
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (bus.fetch_halted !== 1'b0) begin errors++; $display("FAIL rh_halted: got %b want 0", bus.fetch_halted); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b want 0", bus.ifid_valid); end
        checks++; if (bus.ifid_ins !== 32'd0) begin errors++; $display("FAIL rh_ins: got %h want 0", bus.ifid_ins); end
        checks++; if (bus.imemaddr !== 32'd0) begin errors++; $display("FAIL rh_addr: got %h want 0", bus.imemaddr); end
        checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL rh_ren: got %b want 1", bus.imemREN); end
    endtask

    task automatic test_reset_drain();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h80;
        step();
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (bus.imemaddr !== 32'd0) begin errors++; $display("FAIL rd_addr: got %h want 0", bus.imemaddr); end
        checks++; if (bus.ifid_pc !== 32'd0) begin errors++; $display("FAIL rd_ifpc: got %h want 0", bus.ifid_pc); end
        bus.ihit = 1'b1;
        bus.imemload = 32'h2008_0008;
        step();
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL rd_cap_valid: got %b want 1", bus.ifid_valid); end
        checks++; if (bus.imemaddr !== 32'h4) begin errors++; $display("FAIL rd_next_addr: got %h want 4", bus.imemaddr); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_miss();
        test_stall();
        test_redirect();
        test_flush();
        test_halt();
        test_wrap();
        test_reset_halted();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
